cipher_job_arbiter: RTL and testbench

Shares one 36-bit block-cipher core (144-bit key, level `encrypt_en` start, `encr_done` completion) between two requesters. Each job is a block plus key, arbitrated round-robin. The block drives the core's plaintext, key and enable, waits for completion or a watchdog timeout, and returns the 36-bit result tagged with the requester ID. It enforces a minimum enable-low gap between jobs so the core re-initialises cleanly.

---
 rtl/cipher_job_arbiter.sv | 147 ++++++++++++++
 tb/tb_cipher_job_arbiter.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cipher_job_arbiter.sv
// Round-robin arbiter sharing one 36-bit block-cipher core between two requesters.
// Drives the core, waits for completion or a watchdog timeout, then holds an enable-low gap.
module cipher_job_arbiter #(
  parameter int GAP_CYCLES = 4,
  parameter int TIMEOUT    = 127
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [35:0]  req0_block,
  input  logic [143:0] req0_key,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [35:0]  req1_block,
  input  logic [143:0] req1_key,
  output logic         resp_valid,
  input  logic         resp_ready,
  output logic [35:0]  resp_data,
  output logic         resp_id,
  output logic         resp_err,
  output logic         busy,
  output logic [35:0]  core_s_i,
  output logic [143:0] core_keyin,
  output logic         core_encrypt_en,
  input  logic [35:0]  core_s_j,
  input  logic         core_encr_done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_RESP,
    S_GAP
  } state_t;

  // The watchdog counts completed RUN cycles, so it fires in RUN cycle TIMEOUT+1.
  localparam logic [7:0] WD_LAST  = 8'(TIMEOUT);
  localparam logic [3:0] GAP_INIT = 4'(GAP_CYCLES);

  state_t         state_q, state_d;
  logic           last_q, last_d;
  logic [7:0]     wd_q, wd_d;
  logic [3:0]     gap_q, gap_d;
  logic [35:0]    s_i_q, s_i_d;
  logic [143:0]   key_q, key_d;
  logic [35:0]    data_q, data_d;
  logic           id_q, id_d;
  logic           err_q, err_d;
  logic           grant;

  // last_q records the requester served most recently; on a tie the other one wins.
  assign grant      = req1_valid & (~req0_valid | ~last_q);
  assign req0_ready = (state_q == S_IDLE) & req0_valid & ~grant;
  assign req1_ready = (state_q == S_IDLE) & req1_valid & grant;

  assign core_encrypt_en = (state_q == S_RUN);
  assign resp_valid      = (state_q == S_RESP);
  assign busy            = (state_q != S_IDLE);
  assign core_s_i        = s_i_q;
  assign core_keyin      = key_q;
  assign resp_data       = data_q;
  assign resp_id         = id_q;
  assign resp_err        = err_q;

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    wd_d    = wd_q;
    gap_d   = gap_q;
    s_i_d   = s_i_q;
    key_d   = key_q;
    data_d  = data_q;
    id_d    = id_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (req0_ready || req1_ready) begin
          s_i_d   = grant ? req1_block : req0_block;
          key_d   = grant ? req1_key : req0_key;
          id_d    = grant;
          last_d  = grant;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        wd_d    = 8'd0;
        state_d = S_RUN;
      end
      S_RUN: begin
        // Completion takes priority over a coincident timeout.
        if (core_encr_done) begin
          data_d  = core_s_j;
          err_d   = 1'b0;
          state_d = S_RESP;
        end else if (wd_q == WD_LAST) begin
          data_d  = 36'd0;
          err_d   = 1'b1;
          state_d = S_RESP;
        end else begin
          wd_d = wd_q + 8'd1;
        end
      end
      S_RESP: begin
        if (resp_ready) begin
          if (GAP_CYCLES == 0) begin
            state_d = S_IDLE;
          end else begin
            gap_d   = GAP_INIT;
            state_d = S_GAP;
          end
        end
      end
      S_GAP: begin
        if (gap_q == 4'd0) state_d = S_IDLE;
        else gap_d = gap_q - 4'd1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      last_q  <= 1'b1;
      wd_q    <= 8'd0;
      gap_q   <= 4'd0;
      s_i_q   <= 36'd0;
      key_q   <= 144'd0;
      data_q  <= 36'd0;
      id_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      wd_q    <= wd_d;
      gap_q   <= gap_d;
      s_i_q   <= s_i_d;
      key_q   <= key_d;
      data_q  <= data_d;
      id_q    <= id_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_cipher_job_arbiter.sv
// Scoreboard bench for cipher_job_arbiter with a behavioural cipher-core model.
module tb_cipher_job_arbiter;
  localparam int GAP_CYCLES = 4;
  localparam int TIMEOUT    = 127;
  localparam logic [35:0]  XMASK = 36'h032547698;
  localparam logic [143:0] KEY_A = {36{4'hA}};
  localparam logic [143:0] KEY_5 = {36{4'h5}};

  logic clk = 1'b0;
  logic rst_n;
  logic req0_valid, req1_valid, req0_ready, req1_ready;
  logic [35:0] req0_block, req1_block;
  logic [143:0] req0_key, req1_key;
  logic resp_valid, resp_ready;
  logic [35:0] resp_data;
  logic resp_id, resp_err, busy;
  logic [35:0] core_s_i, core_s_j;
  logic [143:0] core_keyin;
  logic core_encrypt_en, core_encr_done;

  always #5 clk = ~clk;

  cipher_job_arbiter #(.GAP_CYCLES(GAP_CYCLES), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_block(req0_block), .req0_key(req0_key),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_block(req1_block), .req1_key(req1_key),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data), .resp_id(resp_id),
    .resp_err(resp_err), .busy(busy), .core_s_i(core_s_i), .core_keyin(core_keyin),
    .core_encrypt_en(core_encrypt_en), .core_s_j(core_s_j), .core_encr_done(core_encr_done)
  );

  // Core model: done after done_after enable-high cycles (0 = never); stale_hi forces done while idle.
  int core_cnt = 0;
  int done_after = 36;
  bit stale_hi = 1'b0;
  always @(posedge clk) core_cnt <= core_encrypt_en ? core_cnt + 1 : 0;
  assign core_encr_done = (stale_hi && !core_encrypt_en) ||
                          (core_encrypt_en && done_after != 0 && core_cnt == done_after - 1);
  assign core_s_j = core_s_i ^ XMASK;

  typedef struct packed { logic [35:0] data; logic id; logic err; } exp_t;
  exp_t sb_q[$];
  int grants[$];
  int n_tests = 0, n_fail = 0;

  task automatic check_eq(input string tag, input logic [143:0] got, input logic [143:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Monitor state
  int cyc = 0;
  int en_rise_cyc = 0, hs_cyc = 0, resp_hs_cyc = 0;
  int last_en_len = -1, last_lat = -1, last_hs2en = -1, last_gap = -1;
  logic en_prev = 1'b0, rv_prev = 1'b0;
  logic [35:0] cur_block = '0, last_resp_data = '0;
  logic [143:0] cur_key = '0;
  logic last_resp_err = 1'b0;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic note_grant(input logic id);
    exp_t e;
    cur_block = id ? req1_block : req0_block;
    cur_key   = id ? req1_key : req0_key;
    e.err  = (done_after == 0) || (done_after > TIMEOUT + 1);
    e.data = e.err ? 36'd0 : (cur_block ^ XMASK);
    e.id   = id;
    sb_q.push_back(e);
    grants.push_back(int'(id));
    last_gap = cyc - resp_hs_cyc;
    hs_cyc = cyc;
  endtask

  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      if (req0_valid && req0_ready) note_grant(1'b0);
      if (req1_valid && req1_ready) note_grant(1'b1);
      if (core_encrypt_en && !en_prev) begin
        en_rise_cyc = cyc;
        last_hs2en = cyc - hs_cyc;
      end
      if (!core_encrypt_en && en_prev) last_en_len = cyc - en_rise_cyc;
      if (resp_valid && !rv_prev) last_lat = cyc - en_rise_cyc;
      if (core_encrypt_en) begin
        check_eq("run_s_i", core_s_i, cur_block);
        check_eq("run_key", core_keyin, cur_key);
      end
      check_eq("resp_vs_ready_excl", resp_valid & (req0_ready | req1_ready), 0);
      if (resp_valid && resp_ready) begin
        resp_hs_cyc = cyc;
        if (sb_q.size() == 0) begin
          check_eq("sb_unexpected", resp_valid, 0);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          check_eq("resp_data", resp_data, e.data);
          check_eq("resp_id", resp_id, e.id);
          check_eq("resp_err", resp_err, e.err);
          last_resp_data = resp_data;
          last_resp_err = resp_err;
        end
      end
    end
    en_prev = core_encrypt_en;
    rv_prev = resp_valid;
  end

  task automatic wait_ready(input logic id);
    bit ok = 1'b0;
    for (int i = 0; i < 400 && !ok; i++) begin
      @(negedge clk);
      if (id ? req1_ready : req0_ready) ok = 1'b1;
    end
    if (!ok) check_eq("ready_timeout", id ? req1_ready : req0_ready, 1);
    @(posedge clk); #1;
    if (id) req1_valid = 1'b0; else req0_valid = 1'b0;
  endtask

  task automatic send(input logic id, input logic [35:0] blk, input logic [143:0] key);
    @(posedge clk); #1;
    if (id) begin req1_block = blk; req1_key = key; req1_valid = 1'b1; end
    else begin req0_block = blk; req0_key = key; req0_valid = 1'b1; end
    wait_ready(id);
  endtask

  task automatic wait_idle(input int budget);
    bit ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk);
      if (!busy && sb_q.size() == 0) ok = 1'b1;
    end
    if (!ok) check_eq("idle_timeout", busy, 0);
  endtask

  task automatic wait_grants(input int target);
    for (int i = 0; i < 800 && grants.size() < target; i++) @(negedge clk);
    check_eq("grant_count", grants.size(), target);
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation did not finish, got %0d cycles", cyc);
    $fatal(1);
  end

  initial begin
    int base;
    rst_n = 1'b0; resp_ready = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_block = '0; req1_block = '0; req0_key = '0; req1_key = '0;

    // Reset state
    @(negedge clk);
    check_eq("rst_en", core_encrypt_en, 0);
    check_eq("rst_resp_valid", resp_valid, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_resp_data", resp_data, 0);
    check_eq("rst_resp_err", resp_err, 0);
    check_eq("rst_s_i", core_s_i, 0);
    check_eq("rst_keyin", core_keyin, 0);
    check_eq("rst_ready0_novalid", req0_ready, 0);
    req0_valid = 1'b1;
    #1;
    check_eq("rst_ready0_valid", req0_ready, 1);
    check_eq("rst_ready1", req1_ready, 0);
    req0_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Single job
    done_after = 36;
    send(1'b0, 36'h111111111, 144'd0);
    wait_idle(300);
    check_eq("single_data", last_resp_data, 36'h123456789);
    check_eq("single_en_len", last_en_len, 36);
    check_eq("single_lat", last_lat, 36);
    check_eq("single_hs2en", last_hs2en, 2);

    // Timeout, then a normal job
    done_after = 0;
    send(1'b1, 36'h0DEADBEEF, KEY_A);
    wait_idle(400);
    check_eq("to_err", last_resp_err, 1);
    check_eq("to_data", last_resp_data, 0);
    check_eq("to_lat", last_lat, TIMEOUT + 1);
    check_eq("to_en_len", last_en_len, TIMEOUT + 1);
    done_after = 10;
    send(1'b1, 36'h0CAFEF00D, KEY_5);
    wait_idle(300);
    check_eq("post_to_err", last_resp_err, 0);
    check_eq("post_to_en_len", last_en_len, 10);

    // Contention
    done_after = 5;
    @(posedge clk); #1;
    req0_block = 36'h555555555; req0_key = KEY_5;
    req1_block = 36'hAAAAAAAAA; req1_key = KEY_A;
    base = grants.size();
    req0_valid = 1'b1; req1_valid = 1'b1;
    wait_grants(base + 4);
    @(posedge clk); #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    wait_idle(300);
    for (int i = 0; i < 4; i++)
      if (base + i < grants.size()) check_eq("grant_order", grants[base + i], i % 2);

    // Backpressure and gap
    done_after = 3;
    resp_ready = 1'b0;
    send(1'b0, 36'h13579BDF0, KEY_A);
    for (int i = 0; i < 100 && !resp_valid; i++) @(negedge clk);
    @(posedge clk); #1;
    req1_block = 36'h2468ACE13; req1_key = KEY_5; req1_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check_eq("bp_valid", resp_valid, 1);
      check_eq("bp_data", resp_data, 36'h13579BDF0 ^ XMASK);
      check_eq("bp_id", resp_id, 0);
      check_eq("bp_en", core_encrypt_en, 0);
      check_eq("bp_ready1", req1_ready, 0);
    end
    @(posedge clk); #1;
    resp_ready = 1'b1;
    wait_ready(1'b1);
    check_eq("gap_len", last_gap, GAP_CYCLES + 2);
    wait_idle(300);

    // Stale done level
    stale_hi = 1'b1;
    done_after = 20;
    send(1'b0, 36'h0F0F0F0F0, KEY_A);
    wait_idle(300);
    check_eq("stale_en_len", last_en_len, 20);
    done_after = TIMEOUT + 1;
    send(1'b1, 36'h0FEDCBA98, KEY_5);
    wait_idle(400);
    check_eq("edge_err", last_resp_err, 0);
    check_eq("edge_data", last_resp_data, 36'h0FEDCBA98 ^ XMASK);
    check_eq("edge_en_len", last_en_len, TIMEOUT + 1);
    stale_hi = 1'b0;

    // Reset mid-RUN
    done_after = 0;
    send(1'b0, 36'h3C3C3C3C3, KEY_A);
    for (int i = 0; i < 100 && !(core_encrypt_en && cyc - en_rise_cyc == 9); i++) @(negedge clk);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_en", core_encrypt_en, 0);
    check_eq("mid_rst_busy", busy, 0);
    check_eq("mid_rst_valid", resp_valid, 0);
    check_eq("mid_rst_data", resp_data, 0);
    check_eq("mid_rst_s_i", core_s_i, 0);
    check_eq("mid_rst_keyin", core_keyin, 0);
    sb_q.delete();
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check_eq("aborted_no_resp", resp_valid, 0);
    end
    done_after = 4;
    @(posedge clk); #1;
    base = grants.size();
    req0_block = 36'h777777777; req1_block = 36'h888888888;
    req0_valid = 1'b1; req1_valid = 1'b1;
    wait_grants(base + 1);
    @(posedge clk); #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    if (grants.size() > base) check_eq("ptr_after_rst", grants[base], 0);
    wait_idle(300);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
